ssb_agc_demod: RTL and testbench
================================

SSB_AGC_DEMOD -- requirements
Module: ssb_agc_demod

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 The ports SHALL be, in this order:
- clk, input, 1, clock
- rst, input, 1, synchronous active-high reset
- I_in, input, 32 signed, group-delayed I sample from the Hilbert stage
- Q_in, input, 32 signed, Hilbert-transformed Q sample
- data_valid, input, 1, one-cycle strobe qualifying I_in/Q_in
- sideband, input, 1, 0 = USB (I-Q), 1 = LSB (I+Q)
- agc_enable, input, 1, 1 = automatic gain, 0 = manual_gain used
- manual_gain, input, 16 unsigned Q8.8, manual gain
- attack_shift, input, 4, envelope attack shift
- decay_shift, input, 4, envelope decay shift
- target_level, input, 15 unsigned, AGC target envelope
- audio_out, output, 16 signed, demodulated audio
- audio_valid, output, 1, one-cycle strobe qualifying audio_out
- gain_out, output, 16 unsigned Q8.8, current gain
- busy, output, 1, high while a sample is being processed
- overrun, output, 1, sticky flag for a data_valid dropped while busy
REQ-003 Parameters SHALL be:
- GAIN_MIN, 16'h0001, lowest gain the AGC can set
- GAIN_MAX, 16'hFFFF, highest gain the AGC can set
- GAIN_RESET, 16'h0100, gain after reset (unity)

Function
REQ-004 The FSM SHALL have the states IDLE, COMBINE, SCALE, AGC_UPD.
- IDLE -> COMBINE on data_valid.
- COMBINE -> SCALE -> AGC_UPD -> IDLE, unconditionally.
REQ-005 In IDLE, a data_valid SHALL capture I_in, Q_in and sideband.
REQ-006 COMBINE SHALL form a 33-bit sum (USB I-Q, LSB I+Q) and saturate it to signed 32 bits (0x7FFFFFFF / 0x80000000).
REQ-007 COMBINE SHALL latch the working gain: manual_gain when agc_enable=0, otherwise the internal gain register.
REQ-008 SCALE SHALL compute the full-precision product of the signed combined value and the unsigned gain, arithmetic-shift it right by 8, then shift it right by a further 16, and saturate the result to signed 16 bits.
REQ-009 In AGC_UPD, audio_out SHALL be registered and audio_valid SHALL pulse for exactly one cycle.
- Latency is 4 cycles from data_valid to audio_valid.
REQ-010 The envelope update SHALL use a 16-bit unsigned envelope env and the magnitude m = |audio_out|, with |-32768| saturated to 32767.
- If m > env: env += (m-env)>>attack_shift.
- Otherwise: env -= env>>decay_shift.
REQ-011 When agc_enable=1, the gain update SHALL follow the envelope after it is updated.
- If env > target_level: gain -= 1, clamped at GAIN_MIN.
- If env < target_level>>1: gain += 1, clamped at GAIN_MAX.
- Otherwise the gain holds.
REQ-012 When agc_enable=0, the gain register SHALL load manual_gain every cycle, so that re-enabling the AGC starts from the manual value.
REQ-013 A data_valid outside IDLE SHALL be dropped, SHALL set overrun, and SHALL NOT alter the sample in flight.
- overrun clears only on rst.
REQ-014 busy SHALL be high in COMBINE, SCALE and AGC_UPD.
REQ-015 gain_out SHALL always reflect the gain register.
REQ-016 Changes to sideband, attack_shift or decay_shift mid-sample SHALL NOT affect the sample in flight, except that shifts are sampled in AGC_UPD.

Reset
REQ-017 rst SHALL return the block to a known state.
- State goes to IDLE.
- audio_out=0, audio_valid=0, busy=0, overrun=0.
- env=0 and gain=GAIN_RESET.
- All pipeline registers are 0.
REQ-018 rst asserted mid-sample SHALL abort the sample with no audio_valid pulse.
- A data_valid coincident with rst is ignored.

Structure
REQ-019 The FSM state encoding, GAIN_MIN, GAIN_MAX, GAIN_RESET and the Q8.8 format constant SHALL reside in a shared package sdr_dsp_pkg.
REQ-020 The signed saturation SHALL be one parameterised sub-module sat_signed (input width, output width), instantiated for 33->32 and for the 16-bit output.

Verification
REQ-021 USB: I=0x10000000, Q=0x08000000, agc_enable=0, manual_gain=0x0100 -> audio_out=0x0800, audio_valid exactly 4 cycles after data_valid.
REQ-022 LSB: same I, Q and gain -> audio_out=0x1800; with manual_gain=0x0080 -> audio_out=0x0C00.
REQ-023 Saturation: I=0x7FFFFFFF, Q=0x80000000, USB, gain 0x0200 -> audio_out=0x7FFF; with LSB and I=Q=0x80000000 -> audio_out=0x8000.
REQ-024 AGC: agc_enable=1, target_level=1000, attack_shift=0, decay_shift=4, constant audio-producing input 0x10000000 -> the gain decreases by 1 per sample until the envelope settles in [500,1000] and is never below 1.
REQ-025 Overrun: a second data_valid 2 cycles after the first -> exactly one audio_valid, overrun=1 and held, first result correct.
REQ-026 Reset: rst asserted in SCALE -> no audio_valid, gain_out=0x0100, busy=0 the next cycle, and the next sample processes normally.

Source files
------------

// File: rtl/sdr_dsp_pkg.sv
// sdr_dsp_pkg: shared constants and helpers for the SDR DSP blocks.
//   state_t    : sample-processing FSM states of ssb_agc_demod
//   GAIN_*     : AGC gain limits and the gain loaded at reset (Q8.8)
//   Q88_FRAC   : fractional bit count of the Q8.8 gain format
//   mag16      : magnitude of a signed 16-bit sample, |-32768| -> 32767
package sdr_dsp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMBINE = 2'd1,
      SCALE   = 2'd2,
      AGC_UPD = 2'd3
   } state_t;

   localparam logic [15:0] GAIN_MIN   = 16'h0001;
   localparam logic [15:0] GAIN_MAX   = 16'hFFFF;
   localparam logic [15:0] GAIN_RESET = 16'h0100;

   localparam int unsigned Q88_FRAC = 8;

   function automatic logic [15:0] mag16(input logic signed [15:0] x);
      if (x == 16'sh8000) begin
         return 16'h7FFF;
      end
      else if (x[15]) begin
         return ~x + 16'd1;
      end
      else begin
         return x;
      end
   endfunction

endpackage

// File: rtl/sat_signed.sv
// sat_signed: saturate a signed IN_W-bit value to signed OUT_W bits.
//   din  : signed input, IN_W bits
//   dout : signed output, OUT_W bits, clamped to the OUT_W-bit range
module sat_signed #(
   parameter int unsigned IN_W  = 33,
   parameter int unsigned OUT_W = 32
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout
);

   // Value fits when every bit from the output sign bit upward matches.
   logic [IN_W-OUT_W:0] upper;

   always_comb begin
      upper = din[IN_W-1:OUT_W-1];
      if ((upper == '0) || (upper == '1)) begin
         dout = din[OUT_W-1:0];
      end
      else if (din[IN_W-1]) begin
         dout = {1'b1, {(OUT_W-1){1'b0}}};
      end
      else begin
         dout = {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/ssb_agc_demod.sv
// ssb_agc_demod: SSB demodulator (I-Q for USB, I+Q for LSB) with Q8.8 gain
// scaling and an envelope-following AGC. One sample in flight at a time.
//   clk, rst      : clock, synchronous active-high reset
//   I_in, Q_in    : signed 32-bit input samples, qualified by data_valid
//   sideband      : 0 = USB, 1 = LSB
//   agc_enable    : 1 = AGC drives the gain, 0 = manual_gain (Q8.8) used
//   attack_shift, decay_shift, target_level : envelope / AGC controls
//   audio_out     : signed 16-bit audio, qualified by audio_valid pulse
//   gain_out      : current gain register (Q8.8)
//   busy          : sample being processed
//   overrun       : sticky, set when data_valid arrives while busy
module ssb_agc_demod #(
   parameter logic [15:0] GAIN_MIN   = sdr_dsp_pkg::GAIN_MIN,
   parameter logic [15:0] GAIN_MAX   = sdr_dsp_pkg::GAIN_MAX,
   parameter logic [15:0] GAIN_RESET = sdr_dsp_pkg::GAIN_RESET
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [31:0] I_in,
   input  logic signed [31:0] Q_in,
   input  logic               data_valid,
   input  logic               sideband,
   input  logic               agc_enable,
   input  logic [15:0]        manual_gain,
   input  logic [3:0]         attack_shift,
   input  logic [3:0]         decay_shift,
   input  logic [14:0]        target_level,
   output logic signed [15:0] audio_out,
   output logic               audio_valid,
   output logic [15:0]        gain_out,
   output logic               busy,
   output logic               overrun
);

   import sdr_dsp_pkg::*;

   state_t             state_q, state_d;
   logic signed [31:0] i_q, i_d, q_q, q_d;
   logic               sb_q, sb_d;
   logic signed [31:0] comb_q, comb_d;
   logic [15:0]        wgain_q, wgain_d;
   logic signed [15:0] scaled_q, scaled_d;
   logic signed [15:0] audio_q, audio_d;
   logic               av_q, av_d;
   logic [15:0]        env_q, env_d;
   logic [15:0]        gain_q, gain_d;
   logic               ovr_q, ovr_d;

   logic signed [32:0] sum33;
   logic signed [31:0] comb_sat;
   logic signed [48:0] comb_ext, gain_ext, prod, scaled_wide;
   logic signed [15:0] scaled_sat;
   logic [15:0]        mag, env_next;

   // Datapath feeding the saturators.
   always_comb begin
      sum33       = sb_q ? (33'(i_q) + 33'(q_q)) : (33'(i_q) - 33'(q_q));
      comb_ext    = 49'(comb_q);
      gain_ext    = {33'd0, wgain_q};
      prod        = comb_ext * gain_ext;
      scaled_wide = (prod >>> Q88_FRAC) >>> 16;
   end

   sat_signed #(.IN_W(33), .OUT_W(32)) u_sat_comb (
      .din  (sum33),
      .dout (comb_sat)
   );

   sat_signed #(.IN_W(49), .OUT_W(16)) u_sat_audio (
      .din  (scaled_wide),
      .dout (scaled_sat)
   );

   // Envelope follows the sample being emitted this AGC_UPD cycle.
   always_comb begin
      mag = mag16(scaled_q);
      if (mag > env_q) begin
         env_next = env_q + ((mag - env_q) >> attack_shift);
      end
      else begin
         env_next = env_q - (env_q >> decay_shift);
      end
   end

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      q_d      = q_q;
      sb_d     = sb_q;
      comb_d   = comb_q;
      wgain_d  = wgain_q;
      scaled_d = scaled_q;
      audio_d  = audio_q;
      av_d     = 1'b0;
      env_d    = env_q;
      gain_d   = gain_q;
      ovr_d    = ovr_q;

      if (data_valid && (state_q != IDLE)) begin
         ovr_d = 1'b1;
      end

      // Manual mode tracks manual_gain continuously so the AGC resumes from it.
      if (!agc_enable) begin
         gain_d = manual_gain;
      end

      case (state_q)
         IDLE: begin
            if (data_valid) begin
               i_d     = I_in;
               q_d     = Q_in;
               sb_d    = sideband;
               state_d = COMBINE;
            end
         end
         COMBINE: begin
            comb_d  = comb_sat;
            wgain_d = agc_enable ? gain_q : manual_gain;
            state_d = SCALE;
         end
         SCALE: begin
            scaled_d = scaled_sat;
            state_d  = AGC_UPD;
         end
         AGC_UPD: begin
            audio_d = scaled_q;
            av_d    = 1'b1;
            env_d   = env_next;
            if (agc_enable) begin
               if (env_next > {1'b0, target_level}) begin
                  gain_d = (gain_q <= GAIN_MIN) ? GAIN_MIN : gain_q - 16'd1;
               end
               else if (env_next < {2'b00, target_level[14:1]}) begin
                  gain_d = (gain_q >= GAIN_MAX) ? GAIN_MAX : gain_q + 16'd1;
               end
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         i_q      <= '0;
         q_q      <= '0;
         sb_q     <= 1'b0;
         comb_q   <= '0;
         wgain_q  <= '0;
         scaled_q <= '0;
         audio_q  <= '0;
         av_q     <= 1'b0;
         env_q    <= '0;
         gain_q   <= GAIN_RESET;
         ovr_q    <= 1'b0;
      end
      else begin
         state_q  <= state_d;
         i_q      <= i_d;
         q_q      <= q_d;
         sb_q     <= sb_d;
         comb_q   <= comb_d;
         wgain_q  <= wgain_d;
         scaled_q <= scaled_d;
         audio_q  <= audio_d;
         av_q     <= av_d;
         env_q    <= env_d;
         gain_q   <= gain_d;
         ovr_q    <= ovr_d;
      end
   end

   assign audio_out   = audio_q;
   assign audio_valid = av_q;
   assign gain_out    = gain_q;
   assign busy        = (state_q != IDLE);
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_ssb_agc_demod.sv
// tb_ssb_agc_demod: self-checking bench for ssb_agc_demod.
// Fixed vectors with hand-computed results, hand-written overrun/reset
// sequences, and randomized AGC traffic checked against an arithmetic model.
module tb_ssb_agc_demod;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] I_in, Q_in;
   logic        data_valid, sideband, agc_enable;
   logic [15:0] manual_gain;
   logic [3:0]  attack_shift, decay_shift;
   logic [14:0] target_level;
   logic [15:0] audio_out;
   logic        audio_valid;
   logic [15:0] gain_out;
   logic        busy, overrun;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int          m_env;
   logic [15:0] m_gain;

   localparam longint S32_MAX = 64'sd2147483647;
   localparam longint S32_MIN = -64'sd2147483648;

   typedef struct {
      logic [31:0] i;
      logic [31:0] q;
      logic        sb;
      logic [15:0] mg;
      logic [15:0] exp_audio;
   } vec_t;

   vec_t tbl [8];

   always #5 clk = ~clk;

   ssb_agc_demod #(
      .GAIN_MIN   (16'h0001),
      .GAIN_MAX   (16'hFFFF),
      .GAIN_RESET (16'h0100)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .I_in         (I_in),
      .Q_in         (Q_in),
      .data_valid   (data_valid),
      .sideband     (sideband),
      .agc_enable   (agc_enable),
      .manual_gain  (manual_gain),
      .attack_shift (attack_shift),
      .decay_shift  (decay_shift),
      .target_level (target_level),
      .audio_out    (audio_out),
      .audio_valid  (audio_valid),
      .gain_out     (gain_out),
      .busy         (busy),
      .overrun      (overrun)
   );

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Audio = sat16(floor(sat32(I -/+ Q) * gain / 2^24)).
   function automatic logic [15:0] model_audio(input logic [31:0] i, input logic [31:0] q,
                                               input logic sb, input logic [15:0] g);
      longint si, sq, s, p;
      si = longint'($signed(i));
      sq = longint'($signed(q));
      s  = sb ? si + sq : si - sq;
      if (s > S32_MAX) s = S32_MAX;
      if (s < S32_MIN) s = S32_MIN;
      p = (s * longint'({48'd0, g})) >>> 24;
      if (p > 32767) p = 32767;
      if (p < -32768) p = -32768;
      return p[15:0];
   endfunction

   task automatic model_step(input logic [31:0] i, input logic [31:0] q, input logic sb,
                             input logic [15:0] mg, output logic [15:0] exp_a);
      logic [15:0] g;
      int a, m;
      g     = agc_enable ? m_gain : mg;
      exp_a = model_audio(i, q, sb, g);
      a     = int'($signed(exp_a));
      m     = (a < 0) ? -a : a;
      if (m > 32767) m = 32767;
      if (m > m_env) m_env = m_env + ((m - m_env) >> attack_shift);
      else           m_env = m_env - (m_env >> decay_shift);
      if (agc_enable) begin
         if (m_env > int'(target_level)) begin
            if (m_gain > 16'h0001) m_gain = m_gain - 16'd1;
         end
         else if (m_env < int'(target_level) / 2) begin
            if (m_gain < 16'hFFFF) m_gain = m_gain + 16'd1;
         end
      end
      else begin
         m_gain = mg;
      end
   endtask

   // Issues one sample, then scrambles the inputs so a late change would show.
   task automatic run_sample(input logic [31:0] i, input logic [31:0] q, input logic sb,
                             output logic [15:0] aud, output int lat);
      I_in       = i;
      Q_in       = q;
      sideband   = sb;
      data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      sideband   = ~sb;
      I_in       = $urandom;
      Q_in       = $urandom;
      lat        = 1;
      while (!audio_valid && lat < 12) begin
         tick();
         lat++;
      end
      aud = audio_out;
   endtask

   initial begin
      logic [15:0] e, aud, prev;
      int lat, pulses, viol;

      tbl[0] = '{32'h10000000, 32'h08000000, 1'b0, 16'h0100, 16'h0800};
      tbl[1] = '{32'h10000000, 32'h08000000, 1'b1, 16'h0100, 16'h1800};
      tbl[2] = '{32'h10000000, 32'h08000000, 1'b1, 16'h0080, 16'h0C00};
      tbl[3] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 16'h0200, 16'h7FFF};
      tbl[4] = '{32'h80000000, 32'h80000000, 1'b1, 16'h0200, 16'h8000};
      tbl[5] = '{32'h00000000, 32'h00000000, 1'b0, 16'h0100, 16'h0000};
      tbl[6] = '{32'hF0000000, 32'h00000000, 1'b0, 16'h0100, 16'hF000};
      tbl[7] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 16'h0001, 16'hFFFF};

      rst = 1'b1; data_valid = 1'b0; sideband = 1'b0; agc_enable = 1'b0;
      manual_gain = 16'h0333; attack_shift = '0; decay_shift = '0;
      target_level = '0; I_in = '0; Q_in = '0;

      // Reset state, with a data_valid coincident with rst.
      tick();
      data_valid = 1'b1;
      tick();
      chk("reset audio_out", audio_out, 16'h0000);
      chk("reset audio_valid", audio_valid, 1'b0);
      chk("reset busy", busy, 1'b0);
      chk("reset overrun", overrun, 1'b0);
      chk("reset gain_out", gain_out, 16'h0100);
      rst = 1'b0;
      data_valid = 1'b0;
      tick();
      chk("dv with rst ignored", busy, 1'b0);
      chk("manual gain load", gain_out, 16'h0333);
      m_env  = 0;
      m_gain = 16'h0333;

      // Fixed vectors, AGC off.
      for (int k = 0; k < 8; k++) begin
         manual_gain = tbl[k].mg;
         model_step(tbl[k].i, tbl[k].q, tbl[k].sb, tbl[k].mg, e);
         run_sample(tbl[k].i, tbl[k].q, tbl[k].sb, aud, lat);
         chk($sformatf("vec%0d audio", k), aud, tbl[k].exp_audio);
         chk($sformatf("vec%0d latency", k), lat, 4);
         chk($sformatf("vec%0d gain_out", k), gain_out, tbl[k].mg);
      end
      chk("busy low at audio_valid", busy, 1'b0);

      // Overrun: second data_valid while the first sample is in SCALE.
      manual_gain = 16'h0100;
      chk("overrun before", overrun, 1'b0);
      model_step(32'h10000000, 32'h08000000, 1'b0, 16'h0100, e);
      I_in = 32'h10000000; Q_in = 32'h08000000; sideband = 1'b0; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      chk("busy in COMBINE", busy, 1'b1);
      tick();
      I_in = 32'h7FFFFFFF; Q_in = 32'h00000000; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      pulses = 0;
      aud = '0;
      for (int c = 0; c < 10; c++) begin
         if (audio_valid) begin
            pulses++;
            aud = audio_out;
         end
         tick();
      end
      chk("overrun pulse count", pulses, 1);
      chk("overrun first result", aud, 16'h0800);
      chk("overrun set", overrun, 1'b1);
      repeat (5) tick();
      chk("overrun sticky", overrun, 1'b1);

      // Reset asserted while the sample is in SCALE.
      I_in = 32'h10000000; Q_in = 32'h08000000; sideband = 1'b0; data_valid = 1'b1;
      tick();
      data_valid = 1'b0;
      tick();
      manual_gain = 16'h0200;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort busy", busy, 1'b0);
      chk("abort gain_out", gain_out, 16'h0100);
      chk("abort overrun cleared", overrun, 1'b0);
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         if (audio_valid) pulses++;
         tick();
      end
      chk("abort no audio_valid", pulses, 0);
      m_env  = 0;
      m_gain = 16'h0200;
      model_step(32'h10000000, 32'h08000000, 1'b0, 16'h0200, e);
      run_sample(32'h10000000, 32'h08000000, 1'b0, aud, lat);
      chk("post-abort audio", aud, 16'h1000);
      chk("post-abort latency", lat, 4);

      // AGC convergence on a constant input.
      rst = 1'b1; agc_enable = 1'b1; attack_shift = 4'd0; decay_shift = 4'd4;
      target_level = 15'd1000; manual_gain = 16'h0555;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("agc start gain", gain_out, 16'h0100);
      m_env  = 0;
      m_gain = 16'h0100;
      prev   = 16'h0100;
      viol   = 0;
      for (int n = 0; n < 260; n++) begin
         model_step(32'h10000000, 32'h00000000, 1'b0, manual_gain, e);
         run_sample(32'h10000000, 32'h00000000, 1'b0, aud, lat);
         chk("agc audio", aud, e);
         chk("agc gain", gain_out, m_gain);
         if (gain_out > prev || gain_out + 16'd1 < prev || gain_out == 16'h0000) viol++;
         prev = gain_out;
      end
      chk("agc step violations", viol, 0);
      chk("agc settled gain", gain_out, 16'd62);

      // Randomized AGC traffic.
      for (int n = 0; n < 60; n++) begin
         logic [31:0] ri, rq;
         logic        rsb;
         attack_shift = 4'($urandom_range(0, 15));
         decay_shift  = 4'($urandom_range(0, 15));
         target_level = 15'($urandom);
         ri  = 32'($signed($urandom) >>> $urandom_range(0, 20));
         rq  = 32'($signed($urandom) >>> $urandom_range(0, 20));
         rsb = 1'($urandom);
         model_step(ri, rq, rsb, manual_gain, e);
         run_sample(ri, rq, rsb, aud, lat);
         chk("rand audio", aud, e);
         chk("rand gain", gain_out, m_gain);
         chk("rand latency", lat, 4);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
